// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32I load/store funct3 encodings (F3_*)
//   - FSM state type (IDLE / WAIT / RESP)
//   - access_err(): rejects illegal funct3, misaligned half/word and
//     out-of-range word indices
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unsigned loads have no store counterpart, so BU/HU are illegal for stores.
    function automatic logic access_err(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int unsigned depth_words
    );
        logic bad_f3;
        logic misal;
        logic oor;
        bad_f3 = 1'b0;
        misal  = 1'b0;
        case (funct3)
            F3_B:  begin end
            F3_H:  misal = addr[0];
            F3_W:  misal = (addr[1:0] != 2'b00);
            F3_BU: bad_f3 = we;
            F3_HU: begin
                bad_f3 = we;
                misal  = addr[0];
            end
            default: bad_f3 = 1'b1;
        endcase
        oor = ({2'b00, addr[31:2]} >= depth_words);
        return bad_f3 | misal | oor;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: selects the byte/half lane of a memory word and sign- or
// zero-extends it according to the RV32I load funct3.
//   i_word   : full 32-bit memory word
//   i_lane   : addr[1:0] of the access
//   i_funct3 : load funct3
//   o_data   : formatted load result (0 for non-load encodings)
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[8*i_lane +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_data = i_word;
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_HU:   o_data = {16'h0000, w_half};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave for the RV32I load/store port.
// Accepts one request at a time (req_valid/req_ready), waits, then performs
// the store or load and presents the response (rsp_valid/rsp_ready).
//   clk, rst           : clock, asynchronous active-high reset
//   req_valid/ready    : request handshake (req_ready depends on state only)
//   req_we             : 1 = store, 0 = load
//   req_funct3         : RV32I load/store funct3
//   req_addr           : byte address
//   req_wdata          : right-aligned store data
//   rsp_valid/ready    : response handshake
//   rsp_rdata          : load result, 0 for stores and errors
//   rsp_err            : access rejected (memory left untouched)
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [2:0]         r_f3;
    logic [IDX_W+1:0]   r_addr;
    logic [31:0]        r_wdata;
    logic               r_err;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_commit;
    logic               w_err_in;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_word;
    logic [31:0]        w_load;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;

    assign w_accept = (r_state == IDLE) && req_valid;
    // WAIT always runs WAIT_STATES+1 cycles; its last edge is the commit edge.
    assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_err_in = access_err(req_we, req_funct3, req_addr, DEPTH_WORDS);
    assign w_idx    = r_addr[IDX_W+1:2];
    assign w_word   = r_mem[w_idx];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = (r_state == IDLE) && !rst;
        rsp_valid = (r_state == RESP);
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_f3        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= WS_LOAD;
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[IDX_W+1:0];
                r_wdata <= req_wdata;
                r_err   <= w_err_in;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_commit) begin
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_err || r_we) ? '0 : w_load;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    // Store lane placement: replicate the data across lanes, enable only the target ones
    always_comb begin
        w_be     = '0;
        w_wlanes = r_wdata;
        case (r_f3)
            F3_B: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            F3_H: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = '0;
        endcase
    end

    // Memory array (not reset)
    always_ff @(posedge clk) begin
        if (w_commit && !r_err && r_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    mem_load_align u_align (
        .i_word   (w_word),
        .i_lane   (r_addr[1:0]),
        .i_funct3 (r_f3),
        .o_data   (w_load)
    );

endmodule
